// File: rtl/ifu_fetch_if.sv
// Fetch-controller bus: redirect and pop inputs, I-cache request/response port,
// and the two instruction-FIFO write ports.
interface ifu_fetch_if;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [1:0]  pop_cnt;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_ready;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_inst1;
  logic [31:0] ic_resp_inst2;
  logic        w_ena_1;
  logic        w_ena_2;
  logic [63:0] w_data_1;
  logic [63:0] w_data_2;

  modport master (
    input  flush, redirect_pc, pop_cnt, ic_ready, ic_resp_valid, ic_resp_inst1, ic_resp_inst2,
    output ic_req, ic_addr, w_ena_1, w_ena_2, w_data_1, w_data_2
  );

  modport slave (
    output flush, redirect_pc, pop_cnt, ic_ready, ic_resp_valid, ic_resp_inst1, ic_resp_inst2,
    input  ic_req, ic_addr, w_ena_1, w_ena_2, w_data_1, w_data_2
  );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// IFU fetch controller: credit-based fetch issue, in-order tracking of in-flight
// I-cache requests, FIFO write of returned {pc, inst} pairs, and flush draining.
module ifu_fetch_ctrl #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          MAX_OUT    = 2,
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000
) (
  input logic        clk,
  input logic        rst,
  ifu_fetch_if.master fif
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CMP_W = OCC_W + 1;
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t           state;
  logic [31:0]      pc;
  logic [OCC_W-1:0] occ;
  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] stale;
  logic [31:0]      inflight_q [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [1:0]       need;
  logic             credit_ok;
  logic             accept;
  logic             resp_ok;
  logic             resp_wr;
  logic [31:0]      rpc;
  logic [OUT_W-1:0] stale_nx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Occupancy update floors at zero so a stray pop can never wrap the credit count.
  function automatic logic [OCC_W-1:0] occ_next(input logic [OCC_W-1:0] cur,
                                                input logic [1:0] add,
                                                input logic [1:0] sub);
    logic [CMP_W-1:0] sum;
    sum = CMP_W'(cur) + CMP_W'(add);
    occ_next = (sum > CMP_W'(sub)) ? OCC_W'(sum - CMP_W'(sub)) : '0;
  endfunction

  always_comb begin
    need      = pc[2] ? 2'd1 : 2'd2;
    credit_ok = (CMP_W'(occ) + CMP_W'(need)) <= CMP_W'(FIFO_DEPTH);
    resp_ok   = fif.ic_resp_valid & (outstanding != '0);
    resp_wr   = ~rst & resp_ok & (state == RUN) & ~fif.flush;
    rpc       = inflight_q[rd_ptr];
    stale_nx  = outstanding - OUT_W'(resp_ok);
  end

  assign fif.ic_req   = ~rst & (state == RUN) & ~fif.flush &
                        (outstanding < OUT_W'(MAX_OUT)) & credit_ok;
  assign accept       = fif.ic_req & fif.ic_ready;
  assign fif.ic_addr  = pc;
  assign fif.w_ena_1  = resp_wr;
  assign fif.w_ena_2  = resp_wr & ~rpc[2];
  assign fif.w_data_1 = resp_wr ? {rpc, fif.ic_resp_inst1} : '0;
  assign fif.w_data_2 = (resp_wr & ~rpc[2]) ? {rpc + 32'd4, fif.ic_resp_inst2} : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      occ         <= '0;
      outstanding <= '0;
      stale       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (fif.flush) begin
      // Everything still in flight becomes stale; its responses are dropped in DRAIN.
      pc          <= fif.redirect_pc;
      occ         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      stale       <= stale_nx;
      outstanding <= stale_nx;
      state       <= (stale_nx != '0) ? DRAIN : RUN;
    end else if (state == DRAIN) begin
      occ <= occ_next(occ, 2'd0, fif.pop_cnt);
      if (resp_ok) begin
        stale       <= stale - OUT_W'(1);
        outstanding <= outstanding - OUT_W'(1);
        if (stale == OUT_W'(1)) state <= RUN;
      end
    end else begin
      occ         <= occ_next(occ, accept ? need : 2'd0, fif.pop_cnt);
      outstanding <= outstanding + OUT_W'(accept) - OUT_W'(resp_wr);
      if (accept) begin
        pc     <= pc + (pc[2] ? 32'd4 : 32'd8);
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (resp_wr) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) inflight_q[wr_ptr] <= pc;
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: directed scenarios with fixed expectations followed by
// randomized traffic checked against a queue-based model of fetch/response flow.
module tb_ifu_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  ifu_fetch_if bus();

  ifu_fetch_ctrl #(.FIFO_DEPTH(8), .MAX_OUT(2), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .fif(bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.flush = 1'b0; bus.redirect_pc = '0; bus.pop_cnt = '0; bus.ic_ready = 1'b0;
    bus.ic_resp_valid = 1'b0; bus.ic_resp_inst1 = '0; bus.ic_resp_inst2 = '0;
  endtask

  task automatic clean_redirect(input logic [31:0] a);
    idle_inputs();
    bus.flush = 1'b1; bus.redirect_pc = a;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    bus.ic_ready = 1'b1; bus.ic_resp_valid = 1'b1; bus.ic_resp_inst1 = '1; bus.ic_resp_inst2 = '1;
    @(negedge clk);
    n_cmp++; if (bus.ic_req !== 1'b0) begin n_bad++; $display("FAIL reset_ic_req got=%b want=0", bus.ic_req); end
    n_cmp++; if (bus.ic_addr !== RESET_PC) begin n_bad++; $display("FAIL reset_ic_addr got=%h want=%h", bus.ic_addr, RESET_PC); end
    n_cmp++; if (bus.w_ena_1 !== 1'b0 || bus.w_ena_2 !== 1'b0) begin n_bad++; $display("FAIL reset_w_ena got=%b%b want=00", bus.w_ena_1, bus.w_ena_2); end
    n_cmp++; if (bus.w_data_1 !== 64'd0 || bus.w_data_2 !== 64'd0) begin n_bad++; $display("FAIL reset_w_data got=%h/%h want=0", bus.w_data_1, bus.w_data_2); end
    tick();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (bus.ic_req !== 1'b1 || bus.ic_addr !== RESET_PC) begin n_bad++; $display("FAIL first_req got=%b@%h want=1@%h", bus.ic_req, bus.ic_addr, RESET_PC); end
    tick();
  endtask

  task automatic test_stream;
    int fifo = 0;
    int pv;
    logic [31:0] a, prev;
    for (int k = 0; k < 8; k++) begin
      pv = (fifo >= 2) ? 2 : fifo;
      bus.ic_ready = 1'b1; bus.ic_resp_valid = (k > 0); bus.pop_cnt = 2'(pv);
      bus.ic_resp_inst1 = 32'h1100_0000 + 32'(k); bus.ic_resp_inst2 = 32'h2200_0000 + 32'(k);
      @(negedge clk);
      a = RESET_PC + 32'(8 * k);
      prev = a - 32'd8;
      n_cmp++; if (bus.ic_req !== 1'b1 || bus.ic_addr !== a) begin n_bad++; $display("FAIL stream_req got=%b@%h want=1@%h", bus.ic_req, bus.ic_addr, a); end
      if (k > 0) begin
        n_cmp++; if (bus.w_ena_1 !== 1'b1 || bus.w_ena_2 !== 1'b1) begin n_bad++; $display("FAIL stream_w_ena got=%b%b want=11", bus.w_ena_1, bus.w_ena_2); end
        n_cmp++; if (bus.w_data_1 !== {prev, bus.ic_resp_inst1}) begin n_bad++; $display("FAIL stream_w_data_1 got=%h want=%h", bus.w_data_1, {prev, bus.ic_resp_inst1}); end
        n_cmp++; if (bus.w_data_2 !== {prev + 32'd4, bus.ic_resp_inst2}) begin n_bad++; $display("FAIL stream_w_data_2 got=%h want=%h", bus.w_data_2, {prev + 32'd4, bus.ic_resp_inst2}); end
      end
      fifo = fifo - pv + ((k > 0) ? 2 : 0);
      tick();
    end
    bus.ic_ready = 1'b0; bus.ic_resp_valid = 1'b1; bus.pop_cnt = 2'd2;
    @(negedge clk);
    n_cmp++; if (bus.w_data_1 !== {RESET_PC + 32'd56, bus.ic_resp_inst1}) begin n_bad++; $display("FAIL stream_last got=%h want=%h", bus.w_data_1, {RESET_PC + 32'd56, bus.ic_resp_inst1}); end
    tick();
    idle_inputs();
  endtask

  task automatic test_redirect;
    idle_inputs();
    bus.flush = 1'b1; bus.redirect_pc = 32'h8000_0004;
    @(negedge clk);
    n_cmp++; if (bus.ic_req !== 1'b0) begin n_bad++; $display("FAIL redir_flush_req got=%b want=0", bus.ic_req); end
    tick();
    bus.flush = 1'b0; bus.ic_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.ic_req !== 1'b1 || bus.ic_addr !== 32'h8000_0004) begin n_bad++; $display("FAIL redir_req got=%b@%h want=1@80000004", bus.ic_req, bus.ic_addr); end
    tick();
    bus.ic_ready = 1'b0; bus.ic_resp_valid = 1'b1;
    bus.ic_resp_inst1 = 32'hCAFE_0001; bus.ic_resp_inst2 = 32'hDEAD_0002;
    @(negedge clk);
    n_cmp++; if (bus.w_ena_1 !== 1'b1 || bus.w_ena_2 !== 1'b0) begin n_bad++; $display("FAIL redir_w_ena got=%b%b want=10", bus.w_ena_1, bus.w_ena_2); end
    n_cmp++; if (bus.w_data_1 !== 64'h8000_0004_CAFE_0001) begin n_bad++; $display("FAIL redir_w_data_1 got=%h want=80000004cafe0001", bus.w_data_1); end
    n_cmp++; if (bus.ic_addr !== 32'h8000_0008) begin n_bad++; $display("FAIL redir_next_addr got=%h want=80000008", bus.ic_addr); end
    tick();
    idle_inputs();
  endtask

  task automatic test_credit;
    int  acc = 0;
    bit  pend = 0;
    clean_redirect(32'h0000_1000);
    for (int c = 0; c < 12; c++) begin
      bus.ic_ready = 1'b1; bus.ic_resp_valid = pend; bus.pop_cnt = 2'd0;
      @(negedge clk);
      pend = bus.ic_req & bus.ic_ready;
      if (pend) acc++;
      tick();
    end
    n_cmp++; if (acc !== 4) begin n_bad++; $display("FAIL credit_accepts got=%0d want=4", acc); end
    bus.ic_ready = 1'b0; bus.ic_resp_valid = 1'b0; bus.pop_cnt = 2'd2;
    @(negedge clk);
    n_cmp++; if (bus.ic_req !== 1'b0) begin n_bad++; $display("FAIL credit_full_req got=%b want=0", bus.ic_req); end
    tick();
    bus.pop_cnt = 2'd0;
    @(negedge clk);
    n_cmp++; if (bus.ic_req !== 1'b1 || bus.ic_addr !== 32'h0000_1020) begin n_bad++; $display("FAIL credit_reissue got=%b@%h want=1@00001020", bus.ic_req, bus.ic_addr); end
    tick();
  endtask

  task automatic test_drain;
    clean_redirect(32'h0000_2000);
    bus.ic_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.ic_req !== 1'b1 || bus.ic_addr !== 32'h2000 + 32'(8 * i)) begin n_bad++; $display("FAIL drain_issue got=%b@%h want=1@%h", bus.ic_req, bus.ic_addr, 32'h2000 + 32'(8 * i)); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (bus.ic_req !== 1'b0) begin n_bad++; $display("FAIL drain_max_out got=%b want=0", bus.ic_req); end
    tick();
    bus.flush = 1'b1; bus.redirect_pc = 32'h3000_0000;
    @(negedge clk);
    n_cmp++; if (bus.ic_req !== 1'b0) begin n_bad++; $display("FAIL drain_flush_req got=%b want=0", bus.ic_req); end
    tick();
    bus.flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.ic_req !== 1'b0) begin n_bad++; $display("FAIL drain_wait_req got=%b want=0", bus.ic_req); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      bus.ic_resp_valid = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.w_ena_1 !== 1'b0 || bus.w_ena_2 !== 1'b0 || bus.ic_req !== 1'b0) begin n_bad++; $display("FAIL drain_discard got=w%b%b req%b want=w00 req0", bus.w_ena_1, bus.w_ena_2, bus.ic_req); end
      tick();
    end
    bus.ic_resp_valid = 1'b0; bus.ic_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.ic_req !== 1'b1 || bus.ic_addr !== 32'h3000_0000) begin n_bad++; $display("FAIL drain_resume got=%b@%h want=1@30000000", bus.ic_req, bus.ic_addr); end
    tick();
  endtask

  task automatic test_flush_resp;
    clean_redirect(32'h0000_4000);
    bus.ic_ready = 1'b1;
    tick();
    tick();
    bus.ic_ready = 1'b0; bus.flush = 1'b1; bus.redirect_pc = 32'h5000_0000; bus.ic_resp_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.w_ena_1 !== 1'b0 || bus.w_ena_2 !== 1'b0) begin n_bad++; $display("FAIL fresp_discard got=%b%b want=00", bus.w_ena_1, bus.w_ena_2); end
    tick();
    bus.flush = 1'b0; bus.ic_resp_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.ic_req !== 1'b0) begin n_bad++; $display("FAIL fresp_drain_req got=%b want=0", bus.ic_req); end
    tick();
    bus.ic_resp_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.w_ena_1 !== 1'b0 || bus.ic_req !== 1'b0) begin n_bad++; $display("FAIL fresp_stale got=w%b req%b want=w0 req0", bus.w_ena_1, bus.ic_req); end
    tick();
    bus.ic_resp_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.ic_req !== 1'b1 || bus.ic_addr !== 32'h5000_0000) begin n_bad++; $display("FAIL fresp_resume got=%b@%h want=1@50000000", bus.ic_req, bus.ic_addr); end
    tick();
  endtask

  task automatic test_stall;
    clean_redirect(32'h0000_6000);
    for (int i = 0; i < 5; i++) begin
      bus.ic_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.ic_req !== 1'b1 || bus.ic_addr !== 32'h6000) begin n_bad++; $display("FAIL stall_hold got=%b@%h want=1@00006000", bus.ic_req, bus.ic_addr); end
      tick();
    end
    bus.ic_ready = 1'b1;
    tick();
    bus.ic_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.ic_addr !== 32'h6008) begin n_bad++; $display("FAIL stall_advance got=%h want=00006008", bus.ic_addr); end
    tick();
  endtask

  typedef struct {logic [31:0] addr; int cyc;} req_t;

  task automatic test_random;
    req_t        rq[$];
    logic [31:0] live[$];
    int          stale, fifo, reserved, need, pv;
    logic [31:0] mpc, rpc, r, lp;
    bit          e_req, e_w1, e_w2, acc, resp, fl;
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (bus.ic_req !== 1'b0 || bus.ic_addr !== RESET_PC) begin n_bad++; $display("FAIL rand_reset got=%b@%h want=0@%h", bus.ic_req, bus.ic_addr, RESET_PC); end
    tick();
    rst = 1'b0;
    mpc = RESET_PC; stale = 0; fifo = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.ic_req !== 1'b0 || bus.w_ena_1 !== 1'b0 || bus.w_ena_2 !== 1'b0 || bus.ic_addr !== RESET_PC) begin n_bad++; $display("FAIL mid_reset got=req%b w%b%b @%h want=req0 w00 @%h", bus.ic_req, bus.w_ena_1, bus.w_ena_2, bus.ic_addr, RESET_PC); end
        tick();
        rst = 1'b0;
        rq.delete(); live.delete();
        mpc = RESET_PC; stale = 0; fifo = 0;
        continue;
      end
      fl = ($urandom_range(0, 99) < 4);
      r  = $urandom();
      bus.flush = fl;
      bus.redirect_pc = {r[31:2], 2'b00};
      bus.ic_ready = ($urandom_range(0, 9) < 7);
      resp = (rq.size() > 0) && (rq[0].cyc < cyc) && ($urandom_range(0, 3) != 0);
      bus.ic_resp_valid = resp;
      bus.ic_resp_inst1 = $urandom();
      bus.ic_resp_inst2 = $urandom();
      pv = (fifo >= 2) ? 2 : fifo;
      pv = (fl || $urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, pv);
      bus.pop_cnt = 2'(pv);

      reserved = 0;
      foreach (live[i]) begin
        lp = live[i];
        reserved += lp[2] ? 1 : 2;
      end
      need  = mpc[2] ? 1 : 2;
      e_req = (stale == 0) && !fl && (live.size() + stale < 2) && (fifo + reserved + need <= 8);
      rpc   = (live.size() > 0) ? live[0] : 32'd0;
      e_w1  = resp && (stale == 0) && !fl;
      e_w2  = e_w1 && !rpc[2];

      @(negedge clk);
      n_cmp++; if (bus.ic_req !== e_req) begin n_bad++; $display("FAIL rand_ic_req cyc=%0d got=%b want=%b", cyc, bus.ic_req, e_req); end
      n_cmp++; if (bus.ic_addr !== mpc) begin n_bad++; $display("FAIL rand_ic_addr cyc=%0d got=%h want=%h", cyc, bus.ic_addr, mpc); end
      n_cmp++; if (bus.w_ena_1 !== e_w1 || bus.w_ena_2 !== e_w2) begin n_bad++; $display("FAIL rand_w_ena cyc=%0d got=%b%b want=%b%b", cyc, bus.w_ena_1, bus.w_ena_2, e_w1, e_w2); end
      if (e_w1) begin
        n_cmp++; if (bus.w_data_1 !== {rpc, bus.ic_resp_inst1}) begin n_bad++; $display("FAIL rand_w_data_1 cyc=%0d got=%h want=%h", cyc, bus.w_data_1, {rpc, bus.ic_resp_inst1}); end
      end
      if (e_w2) begin
        n_cmp++; if (bus.w_data_2 !== {rpc + 32'd4, bus.ic_resp_inst2}) begin n_bad++; $display("FAIL rand_w_data_2 cyc=%0d got=%h want=%h", cyc, bus.w_data_2, {rpc + 32'd4, bus.ic_resp_inst2}); end
      end

      acc = e_req && bus.ic_ready;
      if (resp) begin
        void'(rq.pop_front());
        if (stale > 0) stale--;
        else begin
          void'(live.pop_front());
          if (!fl) fifo += e_w2 ? 2 : 1;
        end
      end
      if (!fl) fifo -= pv;
      if (acc) begin
        live.push_back(mpc);
        rq.push_back('{addr: mpc, cyc: cyc});
        mpc = mpc + (mpc[2] ? 32'd4 : 32'd8);
      end
      if (fl) begin
        stale += live.size();
        live.delete();
        fifo = 0;
        mpc = bus.redirect_pc;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_stream();
    test_redirect();
    test_credit();
    test_drain();
    test_flush_resp();
    test_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
